// File: rtl/seg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl_if
// Description : Bundle of the user-side signals of the multiplexed
//               seven-segment scan controller.
//               master : drives the controls and the value to display
//                        (en, lz_en, load_req, value); observes status
//                        and strobes.
//               slave  : the scan controller itself (load_ack, pend,
//                        digit_val, dig_n).
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_ctrl_if;
  logic        en;         // scan enable, 0 = dark and scan held
  logic        lz_en;      // leading-zero blanking enable
  logic        load_req;   // single-cycle load request
  logic [15:0] value;      // four hex nibbles, [3:0] = least significant digit
  logic        load_ack;   // one-cycle pulse when a loaded value is committed
  logic        pend;       // a loaded value is waiting for commit
  logic [7:0]  digit_val;  // 8'h00-8'h0F hex digit, 8'h10 blank
  logic [3:0]  dig_n;      // active-low one-hot digit strobes

  modport master (
    output en,
    output lz_en,
    output load_req,
    output value,
    input  load_ack,
    input  pend,
    input  digit_val,
    input  dig_n
  );

  modport slave (
    input  en,
    input  lz_en,
    input  load_req,
    input  value,
    output load_ack,
    output pend,
    output digit_val,
    output dig_n
  );
endinterface
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Time-multiplexed scan controller for a 4-digit display.
//               Each digit slot is BLANK_CYC dead cycles (all strobes off)
//               followed by DRIVE_CYC cycles with the slot's strobe low.
//               Slots run 0,1,2,3,0,... A new value is captured into a
//               shadow register at any time and only reaches the displayed
//               register at the end of a full frame (or immediately while
//               the scan is disabled), so a frame never mixes two values.
// Ports       : clk       - sole clock, rising edge
//               rst_n     - asynchronous active-low reset
//               bus.en        - scan enable
//               bus.lz_en     - leading-zero blanking enable
//               bus.load_req  - load strobe, value captured the same cycle
//               bus.value     - value to display
//               bus.load_ack  - one-cycle pulse after a commit
//               bus.pend      - shadow holds an uncommitted value
//               bus.digit_val - decoder code for the current slot
//               bus.dig_n     - active-low one-hot digit strobes
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
  parameter logic [15:0] DRIVE_CYC = 16'd1000,
  parameter logic [15:0] BLANK_CYC = 16'd16
) (
  input  logic           clk,
  input  logic           rst_n,
  seg_scan_ctrl_if.slave bus
);

  localparam logic [7:0]  c_blank_code = 8'h10;
  localparam logic [3:0]  c_all_off    = 4'hF;
  localparam logic [15:0] c_drive_last = DRIVE_CYC - 16'd1;
  localparam logic [15:0] c_blank_last = BLANK_CYC - 16'd1;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t      r_state;
  logic [15:0] r_cnt;
  logic [1:0]  r_idx;
  logic        r_run;        // scan has been (re)started since en was last low
  logic [15:0] r_disp;
  logic [15:0] r_shadow;
  logic        r_pend;
  logic        r_load_ack;
  logic [7:0]  r_digit_val;
  logic [3:0]  r_dig_n;

  // --------------------------------------------------------------------------
  // Next-state wires
  // --------------------------------------------------------------------------
  state_t      w_state_nx;
  logic [15:0] w_cnt_nx;
  logic [1:0]  w_idx_nx;
  logic        w_run_nx;
  logic [7:0]  w_digit_val_nx;
  logic [3:0]  w_dig_n_nx;
  logic [15:0] w_disp_nx;
  logic [15:0] w_shadow_nx;
  logic        w_pend_nx;
  logic        w_last_blank;
  logic        w_last_drive;
  logic        w_frame_end;
  logic        w_commit;

  // Decoder code for digit i of d. A digit above 0 is blanked when it and
  // every more-significant nibble are zero.
  function automatic logic [7:0] f_code(
    input logic [15:0] d,
    input logic [1:0]  i,
    input logic        lz
  );
    logic [3:0] nib;
    logic       upper_zero;
    nib = d[{i, 2'b00} +: 4];
    case (i)
      2'd1:    upper_zero = (d[15:4]  == 12'h000);
      2'd2:    upper_zero = (d[15:8]  == 8'h00);
      2'd3:    upper_zero = (d[15:12] == 4'h0);
      default: upper_zero = 1'b0;
    endcase
    f_code = (lz && upper_zero) ? c_blank_code : {4'h0, nib};
  endfunction

  assign w_last_blank = (r_state == ST_BLANK) && (r_cnt == c_blank_last);
  assign w_last_drive = (r_state == ST_DRIVE) && (r_cnt == c_drive_last);
  assign w_frame_end  = r_run && w_last_drive && (r_idx == 2'd3);

  // While the scan is disabled nothing is on the glass, so a pending value
  // may commit at once instead of waiting for a frame boundary.
  assign w_commit  = r_pend && (!bus.en || w_frame_end);
  assign w_disp_nx = w_commit ? r_shadow : r_disp;

  // A load on the commit cycle refills the shadow; the committed value is
  // the old shadow (read before this edge), and pend stays set.
  assign w_shadow_nx = bus.load_req ? bus.value : r_shadow;
  assign w_pend_nx   = bus.load_req ? 1'b1 : (w_commit ? 1'b0 : r_pend);

  // --------------------------------------------------------------------------
  // Scan FSM: next state and registered-output next values
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_idx_nx       = r_idx;
    w_run_nx       = r_run;
    w_digit_val_nx = r_digit_val;
    w_dig_n_nx     = r_dig_n;

    if (!bus.en) begin
      // Held dark at the start of slot 0; digit_val keeps its last code.
      w_state_nx = ST_BLANK;
      w_cnt_nx   = 16'd0;
      w_idx_nx   = 2'd0;
      w_run_nx   = 1'b0;
      w_dig_n_nx = c_all_off;
    end else if (!r_run) begin
      // First enabled edge: this edge opens the first BLANK cycle of slot 0.
      w_state_nx     = ST_BLANK;
      w_cnt_nx       = 16'd0;
      w_idx_nx       = 2'd0;
      w_run_nx       = 1'b1;
      w_digit_val_nx = f_code(w_disp_nx, 2'd0, bus.lz_en);
      w_dig_n_nx     = c_all_off;
    end else begin
      case (r_state)
        ST_BLANK: begin
          if (w_last_blank) begin
            w_state_nx = ST_DRIVE;
            w_cnt_nx   = 16'd0;
            // The slot's code was latched at slot start; a blank code keeps
            // the strobes off so the two outputs always agree.
            w_dig_n_nx = (r_digit_val == c_blank_code) ? c_all_off
                                                       : ~(4'b0001 << r_idx);
          end else begin
            w_cnt_nx = r_cnt + 16'd1;
          end
        end
        ST_DRIVE: begin
          if (w_last_drive) begin
            w_state_nx     = ST_BLANK;
            w_cnt_nx       = 16'd0;
            w_idx_nx       = r_idx + 2'd1;
            // Uses the post-commit value so a new frame starts clean.
            w_digit_val_nx = f_code(w_disp_nx, r_idx + 2'd1, bus.lz_en);
            w_dig_n_nx     = c_all_off;
          end else begin
            w_cnt_nx = r_cnt + 16'd1;
          end
        end
        default: begin
          w_state_nx = ST_BLANK;
          w_cnt_nx   = 16'd0;
          w_dig_n_nx = c_all_off;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_BLANK;
      r_cnt       <= 16'd0;
      r_idx       <= 2'd0;
      r_run       <= 1'b0;
      r_disp      <= 16'h0000;
      r_shadow    <= 16'h0000;
      r_pend      <= 1'b0;
      r_load_ack  <= 1'b0;
      r_digit_val <= c_blank_code;
      r_dig_n     <= c_all_off;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_idx       <= w_idx_nx;
      r_run       <= w_run_nx;
      r_disp      <= w_disp_nx;
      r_shadow    <= w_shadow_nx;
      r_pend      <= w_pend_nx;
      r_load_ack  <= w_commit;
      r_digit_val <= w_digit_val_nx;
      r_dig_n     <= w_dig_n_nx;
    end
  end

  assign bus.load_ack  = r_load_ack;
  assign bus.pend      = r_pend;
  assign bus.digit_val = r_digit_val;
  assign bus.dig_n     = r_dig_n;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Scoreboard bench for seg_scan_ctrl (DRIVE_CYC=4,
//               BLANK_CYC=2). A reference model derives the expected outputs
//               from the position inside the frame (cycles since the scan
//               started) and pushes one record per clock; a monitor pops and
//               compares after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

  localparam int D  = 4;
  localparam int B  = 2;
  localparam int SL = B + D;
  localparam int FR = 4 * SL;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(
    .DRIVE_CYC (16'd4),
    .BLANK_CYC (16'd2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ack;
    logic       pend;
    logic [7:0] dv;
    logic [3:0] dn;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors   = 0;
  int   checks   = 0;
  int   cyc      = 0;
  int   ack_seen = 0;
  bit   mon_on   = 1'b0;
  bit   cur_lz   = 1'b0;

  // Reference model state
  bit          m_run    = 1'b0;
  int          m_t      = 0;
  bit          m_pend   = 1'b0;
  logic [15:0] m_shadow = 16'h0;
  logic [15:0] m_disp   = 16'h0;
  logic [7:0]  m_code   = 8'h10;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  function automatic logic [7:0] ref_code(input logic [15:0] d, input int slot, input bit lz);
    logic [15:0] upper;
    upper = d >> (4 * slot);
    if (lz && slot != 0 && upper == 16'h0) return 8'h10;
    return {4'h0, upper[3:0]};
  endfunction

  // One clock edge of the reference model, with the inputs sampled there.
  task automatic model_step(input bit en, input bit lz, input bit lr, input logic [15:0] val);
    exp_t e;
    bit   commit;
    int   pos;
    int   slot;
    commit = m_pend && (!en || (m_run && ((m_t + 1) % FR == 0)));
    if (commit) m_disp = m_shadow;
    if (lr) begin
      m_shadow = val;
      m_pend   = 1'b1;
    end else if (commit) begin
      m_pend = 1'b0;
    end
    e.ack  = commit;
    e.pend = m_pend;
    e.dn   = 4'hF;
    if (!en) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      m_run  = 1'b1;
      m_t    = 0;
      m_code = ref_code(m_disp, 0, lz);
    end else begin
      m_t++;
      pos  = m_t % SL;
      slot = (m_t / SL) % 4;
      if (pos == 0) m_code = ref_code(m_disp, slot, lz);
      if (pos >= B && m_code != 8'h10) e.dn = ~(4'b0001 << slot);
    end
    e.dv = m_code;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input bit en, input bit lz, input bit lr, input logic [15:0] val);
    @(negedge clk);
    bus.en       = en;
    bus.lz_en    = lz;
    bus.load_req = lr;
    bus.value    = val;
    model_step(en, lz, lr, val);
  endtask

  task automatic run(input int n, input bit en);
    for (int i = 0; i < n; i++) cycle(en, cur_lz, 1'b0, 16'h0);
  endtask

  // Monitor: compares one expected record per rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (mon_on && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("load_ack", {15'h0, bus.load_ack}, {15'h0, mon_e.ack});
      check("pend", {15'h0, bus.pend}, {15'h0, mon_e.pend});
      check("digit_val", {8'h0, bus.digit_val}, {8'h0, mon_e.dv});
      check("dig_n", {12'h0, bus.dig_n}, {12'h0, mon_e.dn});
      if (bus.load_ack === 1'b1) ack_seen++;
    end
  end

  initial begin
    int guard;
    bus.en       = 1'b0;
    bus.lz_en    = 1'b0;
    bus.load_req = 1'b0;
    bus.value    = 16'h0;

    // Reset values, before any clock edge
    #1 rst_n = 1'b0;
    #1;
    check("rst_dig_n", {12'h0, bus.dig_n}, 16'hF);
    check("rst_digit_val", {8'h0, bus.digit_val}, 16'h10);
    check("rst_pend", {15'h0, bus.pend}, 16'h0);
    check("rst_load_ack", {15'h0, bus.load_ack}, 16'h0);

    @(negedge clk);
    rst_n  = 1'b1;
    mon_on = 1'b1;

    // First enabled edge opens slot 0 showing 00; then load 1234
    cur_lz = 1'b0;
    run(3, 1'b1);
    cycle(1'b1, cur_lz, 1'b1, 16'h1234);
    run(3 * FR, 1'b1);

    // Leading-zero blanking
    cur_lz = 1'b1;
    cycle(1'b1, cur_lz, 1'b1, 16'h0070);
    run(2 * FR, 1'b1);
    cycle(1'b1, cur_lz, 1'b1, 16'h0000);
    run(2 * FR, 1'b1);

    // Two loads within one frame give a single ack
    cur_lz = 1'b0;
    guard  = 0;
    while (!(m_run && (m_t % FR) == 0) && guard < 2 * FR) begin
      run(1, 1'b1);
      guard++;
    end
    if (guard >= 2 * FR) timeout("frame_align");
    ack_seen = 0;
    cycle(1'b1, cur_lz, 1'b1, 16'hAAAA);
    run(4, 1'b1);
    cycle(1'b1, cur_lz, 1'b1, 16'h5555);
    run(2 * FR, 1'b1);
    @(posedge clk);
    #2;
    check("single_ack", ack_seen[15:0], 16'd1);

    // Load coincident with the commit edge
    cycle(1'b1, cur_lz, 1'b1, 16'h1111);
    guard = 0;
    while (!(m_run && ((m_t + 1) % FR) == 0) && guard < 2 * FR) begin
      run(1, 1'b1);
      guard++;
    end
    if (guard >= 2 * FR) timeout("commit_align");
    cycle(1'b1, cur_lz, 1'b1, 16'h9999);
    run(2 * FR + 4, 1'b1);

    // Drop en during the slot-2 drive phase, load while dark, restart
    guard = 0;
    while (!(m_run && ((m_t / SL) % 4) == 2 && (m_t % SL) >= B) && guard < 2 * FR) begin
      run(1, 1'b1);
      guard++;
    end
    if (guard >= 2 * FR) timeout("slot2_align");
    cycle(1'b0, cur_lz, 1'b0, 16'h0);
    cycle(1'b0, cur_lz, 1'b1, 16'hABCD);
    run(3, 1'b0);
    run(2 * FR, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      bit          en_r;
      bit          lr_r;
      logic [15:0] v;
      en_r = ($urandom_range(0, 99) >= 4);
      if ($urandom_range(0, 99) < 3) cur_lz = ~cur_lz;
      lr_r = ($urandom_range(0, 99) < 6);
      v    = 16'($urandom) >> $urandom_range(0, 16);
      cycle(en_r, cur_lz, lr_r, v);
    end
    run(FR, 1'b1);

    // Asynchronous reset in the middle of a drive phase
    @(posedge clk);
    #2;
    mon_on = 1'b0;
    exp_q.delete();
    guard = 0;
    while (bus.dig_n === 4'hF && guard < 3 * FR) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 3 * FR) timeout("lit_wait");
    bus.load_req = 1'b1;
    bus.value    = 16'h4321;
    @(posedge clk);
    #1;
    bus.load_req = 1'b0;
    check("pre_rst_pend", {15'h0, bus.pend}, 16'h1);
    check("pre_rst_lit", {15'h0, (bus.dig_n != 4'hF)}, 16'h1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_dig_n", {12'h0, bus.dig_n}, 16'hF);
    check("async_rst_digit_val", {8'h0, bus.digit_val}, 16'h10);
    check("async_rst_pend", {15'h0, bus.pend}, 16'h0);
    check("async_rst_load_ack", {15'h0, bus.load_ack}, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DRIVE_CYC, default 16'd1000: clock cycles a digit is driven per slot (legal range 1..65535).
REQ-002 SHALL have parameter BLANK_CYC, default 16'd16: dead-time cycles, all digits off, before each drive phase (legal range 1..65535).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  scan enable; 0 = display dark, scan held.
REQ-006 SHALL have port lz_en  input  1  leading-zero blanking enable.
REQ-007 SHALL have port load_req  input  1  single-cycle request to load value.
REQ-008 SHALL have port value  input  16  four hex nibbles; [3:0] = digit 0 (LSD), [15:12] = digit 3 (MSD).
REQ-009 SHALL have port load_ack  output  1  one-cycle pulse when a loaded value becomes displayed.
REQ-010 SHALL have port pend  output  1  high while an accepted value awaits commit.
REQ-011 SHALL have port digit_val  output  8  code for the downstream segment decoder; 8'h00-8'h0F = hex digit, 8'h10 = blank.
REQ-012 SHALL have port dig_n  output  4  digit-enable strobes, active-low one-hot; 4'hF = all off.

Function
REQ-013 SHALL implement FSM states BLANK and DRIVE with a 16-bit phase counter cnt and a 2-bit digit index idx.
REQ-014 BLANK SHALL last exactly BLANK_CYC cycles, then go to DRIVE with cnt=0.
REQ-015 DRIVE SHALL last exactly DRIVE_CYC cycles, then go to BLANK with idx+1 (3 wraps to 0), giving a frame of 4*(BLANK_CYC+DRIVE_CYC) cycles.
REQ-016 Scan order SHALL be idx 0,1,2,3,0,...
REQ-017 dig_n SHALL be 4'hF throughout BLANK; in DRIVE, bit idx SHALL be 0 and all other bits 1, unless the digit is blanked per REQ-020.
REQ-018 digit_val SHALL be registered and updated on the first BLANK cycle of each slot to {4'h0, disp[4*idx+3:4*idx]}, holding stable through that slot's DRIVE.
REQ-019 disp (16-bit displayed register) SHALL change only on commit; the nibble shown never tears mid-frame.
REQ-020 With lz_en=1, digit i>0 SHALL be blanked when disp nibbles i..3 are all zero: digit_val=8'h10 and dig_n=4'hF for that slot. Digit 0 SHALL never be blanked.
REQ-021 load_req=1 SHALL copy value into shadow and set pend=1 in the same cycle; no back-pressure, and a later load_req before commit overwrites shadow.
REQ-022 Commit (disp<=shadow, pend<=0, load_ack=1 next cycle for exactly one cycle) SHALL occur on the last DRIVE cycle of idx 3 when pend=1.
REQ-023 load_req coincident with a commit cycle SHALL commit the old shadow, capture the new value into shadow, and leave pend=1; exactly one load_ack is issued for that commit.
REQ-024 en=0 SHALL, on the next edge, force state=BLANK, idx=0, cnt=0, dig_n=4'hF; while en=0, a pending value SHALL commit on every cycle with pend=1 (ack per REQ-022).
REQ-025 en 0->1 SHALL restart the scan at BLANK, idx 0, cnt 0.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 rst_n=0 SHALL immediately force state=BLANK, idx=0, cnt=0, disp=16'h0000, shadow=16'h0000, pend=0, load_ack=0, digit_val=8'h10, dig_n=4'hF.
REQ-028 After rst_n release with en=1, the first BLANK SHALL start on the first clock edge, and digit_val SHALL show 8'h00 for idx 0.

Verification (DRIVE_CYC=4, BLANK_CYC=2)
REQ-029 Reset asserted mid-DRIVE -> dig_n=4'hF, digit_val=8'h10, pend=0 without waiting for clk.
REQ-030 en=1, lz_en=0, load 16'h1234 -> load_ack one cycle after the idx-3 DRIVE end; next frame shows (dig_n,digit_val) = (E,04),(D,03),(B,02),(7,01), each 4 cycles after 2 dark cycles.
REQ-031 lz_en=1, value 16'h0070 -> digits 3 and 2 are dark with digit_val 8'h10, digit 1 shows 07, digit 0 shows 00; value 16'h0000 -> only digit 0 lit, showing 00.
REQ-032 Loads of 16'hAAAA then 16'h5555 in the same frame -> a single load_ack, and the display shows 05 on all digits.
REQ-033 en dropped during idx-2 DRIVE -> dig_n=4'hF next cycle; a load commits within 2 cycles; en raised -> 2 BLANK cycles, then idx 0 driven.
REQ-034 load_req on the commit cycle with 16'h9999 while shadow=16'h1111 -> the 1111 frame is displayed, pend stays 1, and 9999 commits at the next frame end.
